m_ifetch_queue: RTL and testbench

//  Instruction-fetch front end for the pipelined RV32I core.
//  - Fetches sequential words from instruction memory over a req/ack + rvalid handshake, with at most one request outstanding.
//  - Buffers {pc, ir} pairs in a DEPTH-entry queue and presents the head to the IF/ID register (P1_ir/P1_pc).
//  - Flushes the queue and redirects on a taken branch or jump from EX.

---
 rtl/m_ifetch_queue_pkg.sv | 22 ++
 rtl/m_ifetch_queue_if.sv | 39 +++
 rtl/m_ifetch_queue_ring.sv | 75 +++++++
 rtl/m_ifetch_queue.sv | 107 ++++++++++
 tb/tb_m_ifetch_queue.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/m_ifetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package m_ifetch_queue_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IFQ_IDLE = 2'd0,
      IFQ_WAIT = 2'd1,
      IFQ_DROP = 2'd2
   } ifq_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] ir;
   } ifq_entry_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~(XLEN'(3));
   endfunction

endpackage

// File: rtl/m_ifetch_queue_if.sv
// Instruction-memory handshake plus the decode-side head port of the fetch queue.
interface m_ifetch_queue_if;
   import m_ifetch_queue_pkg::*;

   logic            w_imem_req;
   logic [XLEN-1:0] w_imem_addr;
   logic            w_imem_ack;
   logic            w_imem_rvalid;
   logic [XLEN-1:0] w_imem_rdata;
   logic            w_stall;
   logic            w_valid;
   logic [XLEN-1:0] w_ir;
   logic [XLEN-1:0] w_pc;

   modport master (
      output w_imem_req,
      output w_imem_addr,
      input  w_imem_ack,
      input  w_imem_rvalid,
      input  w_imem_rdata,
      input  w_stall,
      output w_valid,
      output w_ir,
      output w_pc
   );

   modport slave (
      input  w_imem_req,
      input  w_imem_addr,
      output w_imem_ack,
      output w_imem_rvalid,
      output w_imem_rdata,
      output w_stall,
      input  w_valid,
      input  w_ir,
      input  w_pc
   );

endinterface

// File: rtl/m_ifetch_queue_ring.sv
// DEPTH-entry circular buffer of {pc, ir} pairs with push, pop and synchronous flush.
module m_ifq_ring
   import m_ifetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     w_clk,
   input  logic                     w_rst_n,
   input  logic                     push,
   input  ifq_entry_t               push_data,
   input  logic                     pop,
   input  logic                     flush,
   output ifq_entry_t               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   ifq_entry_t    mem_q [DEPTH];
   ifq_entry_t    mem_d [DEPTH];
   logic          push_en;
   logic          pop_en;

   always_comb begin
      full    = (count_q == (PW+1)'(DEPTH));
      empty   = (count_q == '0);
      count   = count_q;
      head    = mem_q[rd_ptr_q];
      push_en = push && (!full || pop);
      pop_en  = pop && !empty;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;

      // Flush wins over any push/pop arriving in the same cycle.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + (PW+1)'(push_en) - (PW+1)'(pop_en);
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge w_clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/m_ifetch_queue.sv
// Instruction-fetch front end: one-outstanding fetch FSM feeding a small {pc, ir} queue,
// flushed and redirected by taken branches/jumps from EX.
module m_ifetch_queue
   import m_ifetch_queue_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
   input  logic              w_clk,
   input  logic              w_rst_n,
   input  logic              w_redirect,
   input  logic [XLEN-1:0]   w_redirect_pc,
   m_ifetch_queue_if.master  bus
);

   localparam int unsigned PW = $clog2(DEPTH);

   ifq_state_e      state_q, state_d;
   logic [XLEN-1:0] fpc_q, fpc_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

   logic [PW:0]     ring_count;
   logic            ring_full;
   logic            ring_empty;
   ifq_entry_t      ring_head;
   ifq_entry_t      push_entry;
   logic [PW+1:0]   occ;
   logic            imem_req;
   logic            accept;
   logic            push;
   logic            pop;

   // The outstanding request holds a slot, so credit never lets the queue overflow.
   always_comb begin
      occ      = {1'b0, ring_count} + (PW+2)'(state_q != IFQ_IDLE);
      imem_req = w_rst_n && !w_redirect && !ring_full
                 && (occ < (PW+2)'(DEPTH))
                 && ((state_q == IFQ_IDLE) || ((state_q == IFQ_WAIT) && bus.w_imem_rvalid));
      accept   = imem_req && bus.w_imem_ack;
      push     = (state_q == IFQ_WAIT) && bus.w_imem_rvalid && !w_redirect;
      pop      = !ring_empty && !bus.w_stall && !w_redirect;
      push_entry = '{pc: inflight_pc_q, ir: bus.w_imem_rdata};
   end

   always_comb begin
      state_d       = state_q;
      fpc_d         = fpc_q;
      inflight_pc_d = inflight_pc_q;

      if (accept) begin
         fpc_d         = fpc_q + XLEN'(4);
         inflight_pc_d = fpc_q;
      end
      if (w_redirect) begin
         fpc_d = align_word(w_redirect_pc);
      end

      // accept is already suppressed by redirect, which keeps these transitions simple.
      case (state_q)
         IFQ_IDLE: begin
            if (accept) state_d = IFQ_WAIT;
         end
         IFQ_WAIT: begin
            if (bus.w_imem_rvalid) state_d = accept ? IFQ_WAIT : IFQ_IDLE;
            else if (w_redirect)   state_d = IFQ_DROP;
         end
         IFQ_DROP: begin
            if (bus.w_imem_rvalid) state_d = IFQ_IDLE;
         end
         default: state_d = IFQ_IDLE;
      endcase
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q       <= IFQ_IDLE;
         fpc_q         <= RESET_PC;
         inflight_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         fpc_q         <= fpc_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   m_ifq_ring #(
      .DEPTH (DEPTH)
   ) u_ring (
      .w_clk     (w_clk),
      .w_rst_n   (w_rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (w_redirect),
      .head      (ring_head),
      .count     (ring_count),
      .full      (ring_full),
      .empty     (ring_empty)
   );

   assign bus.w_imem_req  = imem_req;
   assign bus.w_imem_addr = fpc_q;
   assign bus.w_valid     = !ring_empty;
   assign bus.w_ir        = ring_empty ? NOP_INSTR : ring_head.ir;
   assign bus.w_pc        = ring_empty ? '0 : ring_head.pc;

endmodule

// File: tb/tb_m_ifetch_queue.sv
// Scoreboard bench for m_ifetch_queue: stimulus queues expected pcs, a monitor checks every pop.
module tb_m_ifetch_queue;
   import m_ifetch_queue_pkg::*;

   logic        w_clk = 1'b0;
   logic        w_rst_n;
   logic        w_redirect;
   logic [31:0] w_redirect_pc;

   int          checks = 0;
   int          errors = 0;
   int          memLat = 1;
   int          pendCnt = 0;
   logic [31:0] pendAddr = '0;
   logic        nextRv;
   logic [31:0] monExp;
   logic [31:0] expQ [$];

   m_ifetch_queue_if bus();

   m_ifetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .w_clk         (w_clk),
      .w_rst_n       (w_rst_n),
      .w_redirect    (w_redirect),
      .w_redirect_pc (w_redirect_pc),
      .bus           (bus)
   );

   always #5 w_clk = ~w_clk;

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return 32'hA500_0000 | addr;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic expectRun(input logic [31:0] start, input int n);
      expQ.delete();
      for (int i = 0; i < n; i++) expQ.push_back(start + 32'(4 * i));
   endtask

   task automatic applyStimulus(input logic redirect, input logic [31:0] rpc, input logic stall);
      @(posedge w_clk);
      #2;
      w_redirect    = redirect;
      w_redirect_pc = rpc;
      bus.w_stall   = stall;
   endtask

   // Memory model: one slot, accepts at negedge, presents rvalid memLat cycles after the ack.
   initial begin
      bus.w_imem_rvalid = 1'b0;
      bus.w_imem_rdata  = 32'hDEAD_BEEF;
      forever begin
         @(negedge w_clk);
         if (w_rst_n && bus.w_imem_req && bus.w_imem_ack) begin
            pendAddr = bus.w_imem_addr;
            pendCnt  = memLat;
         end
         nextRv = 1'b0;
         if (pendCnt > 0) begin
            pendCnt--;
            if (pendCnt == 0) nextRv = 1'b1;
         end
         @(posedge w_clk);
         #1;
         bus.w_imem_rvalid = nextRv;
         bus.w_imem_rdata  = nextRv ? memWord(pendAddr) : 32'hDEAD_BEEF;
      end
   end

   // Monitor: every accepted pop must match the head of the expected queue; bubbles must be nops.
   initial begin
      forever begin
         @(negedge w_clk);
         if (w_rst_n === 1'b1) begin
            if (bus.w_valid && !bus.w_stall && !w_redirect) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_pop: got pc %h, expected no entry", bus.w_pc);
               end else begin
                  monExp = expQ.pop_front();
                  checkOutput("head_pc", bus.w_pc, monExp);
                  checkOutput("head_ir", bus.w_ir, memWord(monExp));
               end
            end else if (!bus.w_valid) begin
               checkOutput("bubble_ir", bus.w_ir, NOP_INSTR);
               checkOutput("bubble_pc", bus.w_pc, 32'h0);
            end
         end
      end
   end

   initial begin
      w_rst_n          = 1'b0;
      w_redirect       = 1'b0;
      w_redirect_pc    = '0;
      bus.w_stall      = 1'b0;
      bus.w_imem_ack   = 1'b1;

      // Reset values
      repeat (3) @(negedge w_clk);
      checkOutput("rst_valid", 32'(bus.w_valid), 32'h0);
      checkOutput("rst_ir", bus.w_ir, 32'h13);
      checkOutput("rst_pc", bus.w_pc, 32'h0);
      checkOutput("rst_req", 32'(bus.w_imem_req), 32'h0);

      // Sequential fetch from RESET_PC, first valid two cycles after release
      @(posedge w_clk);
      #2;
      w_rst_n = 1'b1;
      expectRun(32'h0, 40);
      @(negedge w_clk);
      checkOutput("t1_req0", 32'(bus.w_imem_req), 32'h1);
      checkOutput("t1_addr0", bus.w_imem_addr, 32'h0);
      checkOutput("t1_valid_c0", 32'(bus.w_valid), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge w_clk);
      checkOutput("t1_addr1", bus.w_imem_addr, 32'h4);
      checkOutput("t1_valid_c1", 32'(bus.w_valid), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge w_clk);
      checkOutput("t1_addr2", bus.w_imem_addr, 32'h8);
      checkOutput("t1_valid_c2", 32'(bus.w_valid), 32'h1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0);
         @(negedge w_clk);
         checkOutput("t1_stream_valid", 32'(bus.w_valid), 32'h1);
      end

      // Stall for 10 cycles: queue fills, fetch stops, head holds pc 0x18
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b1);
         @(negedge w_clk);
         checkOutput("t2_head_pc_held", bus.w_pc, 32'h18);
      end
      checkOutput("t2_req_full", 32'(bus.w_imem_req), 32'h0);
      checkOutput("t2_count_full", 32'(dut.ring_count), 32'h4);
      checkOutput("t2_state_idle", 32'(dut.state_q), 32'(IFQ_IDLE));

      // Redirect to 0x100 while full and stalled
      applyStimulus(1'b1, 32'h100, 1'b1);
      expectRun(32'h100, 40);
      @(negedge w_clk);
      checkOutput("t3_req_during_redirect", 32'(bus.w_imem_req), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge w_clk);
      checkOutput("t3_valid_flushed", 32'(bus.w_valid), 32'h0);
      checkOutput("t3_ir_nop", bus.w_ir, 32'h13);
      checkOutput("t3_req_target", 32'(bus.w_imem_req), 32'h1);
      checkOutput("t3_addr_target", bus.w_imem_addr, 32'h100);
      repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);

      // Slow response to 0x20 redirected away to 0x200 while outstanding
      applyStimulus(1'b1, 32'h20, 1'b0);
      memLat = 3;
      expQ.delete();
      @(negedge w_clk);
      checkOutput("t4_req_redirect", 32'(bus.w_imem_req), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge w_clk);
      checkOutput("t4_addr_20", bus.w_imem_addr, 32'h20);
      checkOutput("t4_req_20", 32'(bus.w_imem_req), 32'h1);
      applyStimulus(1'b1, 32'h200, 1'b0);
      expectRun(32'h200, 40);
      @(negedge w_clk);
      checkOutput("t4_req_redirect2", 32'(bus.w_imem_req), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge w_clk);
      checkOutput("t4_state_drop", 32'(dut.state_q), 32'(IFQ_DROP));
      checkOutput("t4_req_drop", 32'(bus.w_imem_req), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      memLat = 1;
      @(negedge w_clk);
      checkOutput("t4_req_drop_rvalid", 32'(bus.w_imem_req), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge w_clk);
      checkOutput("t4_req_after", 32'(bus.w_imem_req), 32'h1);
      checkOutput("t4_addr_200", bus.w_imem_addr, 32'h200);
      checkOutput("t4_count_empty", 32'(dut.ring_count), 32'h0);
      repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);

      // Redirect coinciding with rvalid in WAIT; unaligned target 0x103
      applyStimulus(1'b1, 32'h103, 1'b0);
      expectRun(32'h100, 40);
      @(negedge w_clk);
      checkOutput("t5_state_wait", 32'(dut.state_q), 32'(IFQ_WAIT));
      checkOutput("t5_req_none", 32'(bus.w_imem_req), 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge w_clk);
      checkOutput("t5_state_idle", 32'(dut.state_q), 32'(IFQ_IDLE));
      checkOutput("t5_addr_aligned", bus.w_imem_addr, 32'h100);
      checkOutput("t5_count_zero", 32'(dut.ring_count), 32'h0);
      repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);

      // Asynchronous reset between ack and a late rvalid
      applyStimulus(1'b0, 32'h0, 1'b0);
      memLat = 3;
      @(negedge w_clk);
      @(posedge w_clk);
      #2;
      w_rst_n        = 1'b0;
      bus.w_imem_ack = 1'b0;
      expectRun(32'h0, 40);
      #1;
      checkOutput("t6_rst_valid", 32'(bus.w_valid), 32'h0);
      checkOutput("t6_rst_ir", bus.w_ir, 32'h13);
      checkOutput("t6_rst_pc", bus.w_pc, 32'h0);
      checkOutput("t6_rst_req", 32'(bus.w_imem_req), 32'h0);
      @(posedge w_clk);
      #2;
      w_rst_n = 1'b1;
      @(negedge w_clk);
      checkOutput("t6_req_after_rst", 32'(bus.w_imem_req), 32'h1);
      checkOutput("t6_addr_after_rst", bus.w_imem_addr, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge w_clk);
      checkOutput("t6_state_idle", 32'(dut.state_q), 32'(IFQ_IDLE));
      applyStimulus(1'b0, 32'h0, 1'b0);
      bus.w_imem_ack = 1'b1;
      memLat = 1;
      @(negedge w_clk);
      checkOutput("t6_late_not_pushed", 32'(dut.ring_count), 32'h0);
      checkOutput("t6_addr_restart", bus.w_imem_addr, 32'h0);
      repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);
      @(negedge w_clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
